// File: rtl/doodle_gfx_pkg.sv
// ---------------------------------------------------------------------------
// doodle_gfx_pkg
// Shared graphics constants for the doodle sprite path: default sprite and
// screen dimensions, coordinate widths, and the sprite ROM address layout
// {anim_frame, row, col}. Also provides a small coordinate clamp helper.
// ---------------------------------------------------------------------------
package doodle_gfx_pkg;

  localparam int DEF_SPRITE_W = 32;
  localparam int DEF_SPRITE_H = 32;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_ANIM_DIV = 8;

  // Screen coordinates are 10 bits; window compares use one extra bit so
  // that "left edge + sprite width" never wraps.
  localparam int COORD_W = 10;
  localparam int CMP_W   = COORD_W + 1;

  // Sprite ROM address fields.
  localparam int COL_W  = 5;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = 1 + ROW_W + COL_W;

  typedef struct packed {
    logic             anim_frame;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } sprite_addr_t;

  // Saturate a requested coordinate to the largest legal sprite origin.
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] value,
    input logic [COORD_W-1:0] max_value
  );
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/doodle_sprite_window.sv
// ---------------------------------------------------------------------------
// doodle_sprite_window
// Decides whether the current VGA pixel lies inside the sprite rectangle and
// forms the sprite ROM address for it. Outputs are registered, giving one
// cycle of latency from draw_x/draw_y/pixel_valid.
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   ax, ay         active sprite origin (left edge, top edge)
//   facing_left    mirror the column index horizontally when set
//   anim_frame     animation frame bit placed in the address MSB
//   draw_x, draw_y current VGA pixel position
//   pixel_valid    draw position is inside the visible area
//   is_doodle      registered hit flag
//   sprite_addr    registered ROM address {anim_frame, row, col}, 0 on miss
// ---------------------------------------------------------------------------
module doodle_sprite_window
  import doodle_gfx_pkg::*;
#(
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  ax,
  input  logic [COORD_W-1:0]  ay,
  input  logic                facing_left,
  input  logic                anim_frame,
  input  logic [COORD_W-1:0]  draw_x,
  input  logic [COORD_W-1:0]  draw_y,
  input  logic                pixel_valid,
  output logic                is_doodle,
  output logic [ADDR_W-1:0]   sprite_addr
);

  logic               is_doodle_d, is_doodle_q;
  sprite_addr_t       sprite_addr_d, sprite_addr_q;

  logic [CMP_W-1:0]   draw_x_ext, draw_y_ext;
  logic [CMP_W-1:0]   ax_ext, ay_ext;
  logic [CMP_W-1:0]   x_end, y_end;
  logic               hit;
  logic [COL_W-1:0]   col_off;
  logic [ROW_W-1:0]   row_off;
  logic [COL_W-1:0]   col_sel;

  always_comb begin
    draw_x_ext = {1'b0, draw_x};
    draw_y_ext = {1'b0, draw_y};
    ax_ext     = {1'b0, ax};
    ay_ext     = {1'b0, ay};
    x_end      = ax_ext + CMP_W'(SPRITE_W);
    y_end      = ay_ext + CMP_W'(SPRITE_H);

    hit = pixel_valid
          && (draw_x_ext >= ax_ext) && (draw_x_ext < x_end)
          && (draw_y_ext >= ay_ext) && (draw_y_ext < y_end);

    // Only the low offset bits matter: on a hit the offset is below the
    // sprite size, so truncated subtraction gives the exact index.
    col_off = COL_W'(draw_x - ax);
    row_off = ROW_W'(draw_y - ay);
    col_sel = facing_left ? (COL_W'(SPRITE_W - 1) - col_off) : col_off;

    is_doodle_d   = 1'b0;
    sprite_addr_d = '0;
    if (hit) begin
      is_doodle_d              = 1'b1;
      sprite_addr_d.anim_frame = anim_frame;
      sprite_addr_d.row        = row_off;
      sprite_addr_d.col        = col_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_doodle_q   <= 1'b0;
      sprite_addr_q <= '0;
    end else begin
      is_doodle_q   <= is_doodle_d;
      sprite_addr_q <= sprite_addr_d;
    end
  end

  assign is_doodle   = is_doodle_q;
  assign sprite_addr = sprite_addr_q;

endmodule

// File: rtl/doodle_sprite_gen.sv
// ---------------------------------------------------------------------------
// doodle_sprite_gen
// Sprite position/animation front end for the doodle character. The CPU's
// requested position is latched only on frame_sync (start of vertical blank)
// so the sprite never tears mid-frame. The latched position is clamped to
// the screen, drives the horizontal facing, and an animation counter toggles
// the sprite frame every ANIM_DIV frames. The pixel window test lives in
// doodle_sprite_window.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   doodle_x, doodle_y   requested sprite origin from the PIOs
//   frame_sync           one-cycle pulse at start of vertical blank
//   draw_x, draw_y       current VGA pixel position
//   pixel_valid          draw position is inside the visible area
//   is_doodle            registered: current pixel is inside the sprite
//   sprite_addr          registered: ROM address {anim_frame, row, col}
//   facing_left          current horizontal facing (register output)
// ---------------------------------------------------------------------------
module doodle_sprite_gen
  import doodle_gfx_pkg::*;
#(
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ANIM_DIV = DEF_ANIM_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  doodle_x,
  input  logic [COORD_W-1:0]  doodle_y,
  input  logic                frame_sync,
  input  logic [COORD_W-1:0]  draw_x,
  input  logic [COORD_W-1:0]  draw_y,
  input  logic                pixel_valid,
  output logic                is_doodle,
  output logic [ADDR_W-1:0]   sprite_addr,
  output logic                facing_left
);

  // A divide-by-one still needs a one-bit counter that simply stays at 0.
  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - SPRITE_W);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(SCREEN_H - SPRITE_H);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ANIM_DIV - 1);

  logic [COORD_W-1:0] ax_d, ax_q;
  logic [COORD_W-1:0] ay_d, ay_q;
  logic               facing_left_d, facing_left_q;
  logic [CNT_W-1:0]   frame_cnt_d, frame_cnt_q;
  logic               anim_frame_d, anim_frame_q;

  logic [COORD_W-1:0] new_x, new_y;

  // Everything here changes only on frame_sync; the window sub-module reads
  // the registered values, so a pixel coinciding with frame_sync still sees
  // the previous frame's position, facing and animation frame.
  always_comb begin
    new_x = clamp_coord(doodle_x, X_MAX);
    new_y = clamp_coord(doodle_y, Y_MAX);

    ax_d          = ax_q;
    ay_d          = ay_q;
    facing_left_d = facing_left_q;
    frame_cnt_d   = frame_cnt_q;
    anim_frame_d  = anim_frame_q;

    if (frame_sync) begin
      ax_d = new_x;
      ay_d = new_y;

      // Facing follows the direction of motion; no motion keeps the facing.
      if (new_x > ax_q) begin
        facing_left_d = 1'b0;
      end else if (new_x < ax_q) begin
        facing_left_d = 1'b1;
      end

      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d  = '0;
        anim_frame_d = ~anim_frame_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ax_q          <= '0;
      ay_q          <= '0;
      facing_left_q <= 1'b0;
      frame_cnt_q   <= '0;
      anim_frame_q  <= 1'b0;
    end else begin
      ax_q          <= ax_d;
      ay_q          <= ay_d;
      facing_left_q <= facing_left_d;
      frame_cnt_q   <= frame_cnt_d;
      anim_frame_q  <= anim_frame_d;
    end
  end

  assign facing_left = facing_left_q;

  doodle_sprite_window #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .ax          (ax_q),
    .ay          (ay_q),
    .facing_left (facing_left_q),
    .anim_frame  (anim_frame_q),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .pixel_valid (pixel_valid),
    .is_doodle   (is_doodle),
    .sprite_addr (sprite_addr)
  );

endmodule

// File: tb/tb_doodle_sprite_gen.sv
// ---------------------------------------------------------------------------
// tb_doodle_sprite_gen
// Self-checking bench for doodle_sprite_gen with default parameters. A
// reference model tracks the latched position, facing and number of
// frame_sync pulses seen since reset, and predicts the registered outputs.
// ---------------------------------------------------------------------------
module tb_doodle_sprite_gen;

  logic        clk;
  logic        reset;
  logic [9:0]  doodle_x;
  logic [9:0]  doodle_y;
  logic        frame_sync;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic        pixel_valid;
  logic        is_doodle;
  logic [10:0] sprite_addr;
  logic        facing_left;

  int total;
  int bad;

  // Reference model state.
  int m_x;
  int m_y;
  int m_face;
  int m_syncs;

  doodle_sprite_gen dut (
    .clk         (clk),
    .reset       (reset),
    .doodle_x    (doodle_x),
    .doodle_y    (doodle_y),
    .frame_sync  (frame_sync),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .pixel_valid (pixel_valid),
    .is_doodle   (is_doodle),
    .sprite_addr (sprite_addr),
    .facing_left (facing_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void modelReset();
    m_x     = 0;
    m_y     = 0;
    m_face  = 0;
    m_syncs = 0;
  endfunction

  // Apply one frame_sync to the model: clamp to the screen, then update facing.
  function automatic void modelSync(input int dx, input int dy);
    int nx;
    int ny;
    nx = (dx > 640 - 32) ? 640 - 32 : dx;
    ny = (dy > 480 - 32) ? 480 - 32 : dy;
    if (nx > m_x) m_face = 0;
    else if (nx < m_x) m_face = 1;
    m_x = nx;
    m_y = ny;
    m_syncs++;
  endfunction

  // Expected registered outputs for a pixel, using the model's current state.
  function automatic void predict(input int drx, input int dry, input int pv,
                                  output int hit, output int addr);
    int col;
    int row;
    int anim;
    hit  = 0;
    addr = 0;
    if (pv != 0 && drx >= m_x && drx < m_x + 32 && dry >= m_y && dry < m_y + 32) begin
      hit  = 1;
      row  = dry - m_y;
      col  = (m_face != 0) ? 31 - (drx - m_x) : drx - m_x;
      anim = (m_syncs / 8) % 2;
      addr = anim * 1024 + row * 32 + col;
    end
  endfunction

  task automatic checkOutput(input string tag, input int hit, input int addr);
    total++;
    assert (is_doodle === 1'(hit)) else begin
      bad++;
      $error("[TB] FAIL %s is_doodle observed=%0b required=%0d", tag, is_doodle, hit);
    end
    total++;
    assert (sprite_addr === 11'(addr)) else begin
      bad++;
      $error("[TB] FAIL %s sprite_addr observed=%0d required=%0d", tag, sprite_addr, addr);
    end
    total++;
    assert (facing_left === 1'(m_face)) else begin
      bad++;
      $error("[TB] FAIL %s facing_left observed=%0b required=%0d", tag, facing_left, m_face);
    end
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), clock it, then
  // check the outputs produced by that cycle.
  task automatic applyStimulus(input string tag, input bit fs, input int dx, input int dy,
                               input int drx, input int dry, input bit pv);
    int hit;
    int addr;
    frame_sync  = fs;
    doodle_x    = 10'(dx);
    doodle_y    = 10'(dy);
    draw_x      = 10'(drx);
    draw_y      = 10'(dry);
    pixel_valid = pv;
    predict(drx, dry, int'(pv), hit, addr);
    @(posedge clk);
    #1;
    if (fs) modelSync(dx, dy);
    frame_sync  = 1'b0;
    checkOutput(tag, hit, addr);
  endtask

  // Assert reset mid-cycle, check outputs clear immediately, then release.
  task automatic doReset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput(tag, 0, 0);
    frame_sync  = 1'b0;
    pixel_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fs;
    int drx;
    int dry;
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    doodle_x    = '0;
    doodle_y    = '0;
    frame_sync  = 1'b0;
    draw_x      = '0;
    draw_y      = '0;
    pixel_valid = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_state", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Position latch at (100,200).
    applyStimulus("latch_sync", 1, 100, 200, 0, 0, 0);
    applyStimulus("latch_hit", 0, 555, 333, 100, 200, 1);
    applyStimulus("latch_ignore", 0, 555, 333, 131, 231, 1);
    applyStimulus("latch_below", 0, 555, 333, 131, 232, 1);

    // Clamp: x=1000 becomes 608.
    applyStimulus("clamp_sync", 1, 1000, 200, 0, 0, 0);
    applyStimulus("clamp_607", 0, 1000, 200, 607, 205, 1);
    applyStimulus("clamp_608", 0, 1000, 200, 608, 205, 1);
    applyStimulus("clamp_639", 0, 1000, 200, 639, 200, 1);
    applyStimulus("clamp_640", 0, 1000, 200, 640, 200, 1);
    applyStimulus("clamp_invalid", 0, 1000, 200, 620, 210, 0);

    // Facing: 100 then 90 -> left, mirrored columns; repeat 90 -> held.
    applyStimulus("face_100", 1, 100, 200, 0, 0, 0);
    applyStimulus("face_90", 1, 90, 200, 0, 0, 0);
    applyStimulus("face_col31", 0, 0, 0, 90, 200, 1);
    applyStimulus("face_col0", 0, 0, 0, 121, 203, 1);
    applyStimulus("face_hold", 1, 90, 200, 0, 0, 0);
    applyStimulus("face_right", 1, 95, 200, 95, 200, 1);
    applyStimulus("face_right_hit", 0, 0, 0, 95, 200, 1);

    // Animation: frame bit toggles only on the 8th pulse after reset.
    doReset("anim_reset");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus("anim_sync", 1, 50, 60, 0, 0, 0);
      applyStimulus("anim_hit", 0, 0, 0, 55, 61, 1);
    end

    // Simultaneous frame_sync and pixel: old position still used that cycle.
    doReset("simul_reset");
    applyStimulus("simul_latch", 1, 100, 200, 0, 0, 0);
    applyStimulus("simul_same_cycle", 1, 300, 200, 100, 200, 1);
    applyStimulus("simul_old_pos", 0, 300, 200, 100, 200, 1);
    applyStimulus("simul_new_pos", 0, 300, 200, 300, 200, 1);

    // Reset mid-frame after a latch with facing left.
    applyStimulus("rst_latch_a", 1, 200, 200, 0, 0, 0);
    applyStimulus("rst_latch_b", 1, 100, 200, 0, 0, 0);
    applyStimulus("rst_pre_hit", 0, 0, 0, 100, 200, 1);
    doReset("rst_midframe");
    applyStimulus("rst_origin_hit", 0, 100, 200, 0, 0, 1);
    applyStimulus("rst_old_miss", 0, 100, 200, 100, 200, 1);

    // Randomized traffic, with draw positions biased toward the sprite.
    for (int i = 0; i < 600; i++) begin
      fs = ($urandom_range(0, 5) == 0) ? 1 : 0;
      if ($urandom_range(0, 1) == 0) begin
        drx = m_x + $urandom_range(0, 40);
        dry = m_y + $urandom_range(0, 40);
        if (drx >= 4) drx = drx - 4;
        if (dry >= 4) dry = dry - 4;
      end else begin
        drx = $urandom_range(0, 1023);
        dry = $urandom_range(0, 1023);
      end
      applyStimulus("random", fs[0], $urandom_range(0, 1023), $urandom_range(0, 1023),
                    drx, dry, ($urandom_range(0, 7) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
